// File: rtl/uart_rx_param_if.sv
// Receive-side frame handshake bundle for uart_rx_param.
// The master drives the received frame and its flags; the slave accepts it with rx_ready.
// Defining UART_RX_PARITY_EN adds the parity_err flag to the bundle.
interface uart_rx_param_if #(
   parameter int DATA_W = 8
) ();
   logic [DATA_W-1:0] rx_data;
   logic              rx_valid;
   logic              rx_ready;
   logic              frame_err;
   logic              overrun_err;
`ifdef UART_RX_PARITY_EN
   logic              parity_err;

   modport master (
      output rx_data, rx_valid, frame_err, overrun_err, parity_err,
      input  rx_ready
   );

   modport slave (
      input  rx_data, rx_valid, frame_err, overrun_err, parity_err,
      output rx_ready
   );
`else
   modport master (
      output rx_data, rx_valid, frame_err, overrun_err,
      input  rx_ready
   );

   modport slave (
      input  rx_data, rx_valid, frame_err, overrun_err,
      output rx_ready
   );
`endif
endinterface

// File: rtl/uart_rx_param.sv
// Parametrised oversampling UART receiver.
// Runtime data length (5..DATA_W, clamped) and one or two stop bits.
// Frames are delivered over uart_rx_param_if with framing and overrun flags.
// Optional parity checking is compiled in with the macro UART_RX_PARITY_EN.
// Assumes DATA_W >= 5 and OVS even and >= 8.
module uart_rx_param #(
   parameter int DATA_W      = 8,
   parameter int OVS         = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 tick,
   input  logic                 rx_en,
   input  logic                 rx,
   input  logic [3:0]           n_bits,
   input  logic                 stop_bits,
`ifdef UART_RX_PARITY_EN
   input  logic [1:0]           parity_mode,
`endif
   output logic                 busy,
   uart_rx_param_if.master      bus
);

   localparam int TW = $clog2(OVS);
   localparam int BW = $clog2(DATA_W + 1);
   localparam logic [TW-1:0] T_MID = TW'(OVS / 2 - 1);
   localparam logic [TW-1:0] T_END = TW'(OVS - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
`ifdef UART_RX_PARITY_EN
      S_PAR,
`endif
      S_STOP
   } state_t;

   // Clamp the requested data length into the supported 5..DATA_W range.
   function automatic logic [BW-1:0] clamp_nbits(input logic [3:0] nb);
      logic [BW-1:0] res;
      if (nb < 4'd5)
         res = BW'(5);
      else if (int'(nb) > DATA_W)
         res = BW'(DATA_W);
      else
         res = BW'(nb);
      return res;
   endfunction

   state_t              state, state_nx;
   logic [SYNC_STAGES-1:0] sync;
   logic                rx_s;
   logic [TW-1:0]       tcnt;
   logic [BW-1:0]       bcnt;
   logic [BW-1:0]       nbits_l;
   logic                stop2_l;
   logic                stop_idx;
   logic [DATA_W-1:0]   shreg;
   logic                ferr_acc;
   logic                done_p1;

   logic                tcnt_clr;
   logic                tcnt_inc;
   logic                start_ok;
   logic                data_smp;
   logic                stop_smp;
   logic                stop_last;
   logic                at_mid;
   logic                at_end;
   logic                last_data;

`ifdef UART_RX_PARITY_EN
   logic [1:0]          par_l;
   logic                perr_acc;
   logic                par_smp;
   logic                par_on;

   assign par_on = (par_l == 2'b01) || (par_l == 2'b10);
`endif

   assign rx_s      = sync[SYNC_STAGES-1];
   assign at_mid    = (tcnt == T_MID);
   assign at_end    = (tcnt == T_END);
   assign last_data = (bcnt == nbits_l - BW'(1));
   assign busy      = (state != S_IDLE);

   // Bring the asynchronous line into the clk domain; idle level is high.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         sync <= '1;
      else
         sync <= {sync[SYNC_STAGES-2:0], rx};
   end

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= S_IDLE;
      else
         state <= state_nx;
   end

   // Next-state and per-tick control strobes; nothing advances without tick.
   always_comb begin
      state_nx  = state;
      tcnt_clr  = 1'b0;
      tcnt_inc  = 1'b0;
      start_ok  = 1'b0;
      data_smp  = 1'b0;
      stop_smp  = 1'b0;
      stop_last = 1'b0;
`ifdef UART_RX_PARITY_EN
      par_smp   = 1'b0;
`endif
      case (state)
         S_IDLE: begin
            if (tick && rx_en && !rx_s) begin
               state_nx = S_START;
               tcnt_clr = 1'b1;
            end
         end
         S_START: begin
            if (tick) begin
               if (at_mid) begin
                  tcnt_clr = 1'b1;
                  if (rx_s) begin
                     state_nx = S_IDLE;
                  end else begin
                     state_nx = S_DATA;
                     start_ok = 1'b1;
                  end
               end else begin
                  tcnt_inc = 1'b1;
               end
            end
         end
         S_DATA: begin
            if (tick) begin
               if (at_end) begin
                  tcnt_clr = 1'b1;
                  data_smp = 1'b1;
                  if (last_data) begin
`ifdef UART_RX_PARITY_EN
                     state_nx = par_on ? S_PAR : S_STOP;
`else
                     state_nx = S_STOP;
`endif
                  end
               end else begin
                  tcnt_inc = 1'b1;
               end
            end
         end
`ifdef UART_RX_PARITY_EN
         S_PAR: begin
            if (tick) begin
               if (at_end) begin
                  tcnt_clr = 1'b1;
                  par_smp  = 1'b1;
                  state_nx = S_STOP;
               end else begin
                  tcnt_inc = 1'b1;
               end
            end
         end
`endif
         S_STOP: begin
            if (tick) begin
               if (at_end) begin
                  tcnt_clr = 1'b1;
                  stop_smp = 1'b1;
                  // Leave at the last mid-stop sample so the next start edge is seen early.
                  if (!stop2_l || stop_idx) begin
                     stop_last = 1'b1;
                     state_nx  = S_IDLE;
                  end
               end else begin
                  tcnt_inc = 1'b1;
               end
            end
         end
         default: state_nx = S_IDLE;
      endcase
   end

   // Oversample tick counter, data bit counter and stop bit index.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tcnt     <= '0;
         bcnt     <= '0;
         stop_idx <= 1'b0;
      end else begin
         if (tcnt_clr)
            tcnt <= '0;
         else if (tcnt_inc)
            tcnt <= tcnt + TW'(1);
         if (start_ok)
            bcnt <= '0;
         else if (data_smp)
            bcnt <= bcnt + BW'(1);
         if (start_ok)
            stop_idx <= 1'b0;
         else if (stop_smp)
            stop_idx <= 1'b1;
      end
   end

   // Per-frame settings latched at start validation, shift register and error accumulators.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         nbits_l  <= BW'(5);
         stop2_l  <= 1'b0;
         shreg    <= '0;
         ferr_acc <= 1'b0;
         done_p1  <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_l    <= 2'b00;
         perr_acc <= 1'b0;
`endif
      end else begin
         done_p1 <= stop_last;
         if (start_ok) begin
            nbits_l  <= clamp_nbits(n_bits);
            stop2_l  <= stop_bits;
            shreg    <= '0;
            ferr_acc <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_l    <= parity_mode;
            perr_acc <= 1'b0;
`endif
         end
         // Bits land at their final position, so unused upper bits stay zero.
         if (data_smp)
            shreg <= shreg | (DATA_W'(rx_s) << bcnt);
         if (stop_smp && !rx_s)
            ferr_acc <= 1'b1;
`ifdef UART_RX_PARITY_EN
         // Even mode wants even total ones; odd mode inverts the sense.
         if (par_smp)
            perr_acc <= (^shreg) ^ rx_s ^ (par_l == 2'b10);
`endif
      end
   end

   // ---- output stage: frame presented one cycle after the final stop sample ----
   // Output handshake: load on completion, overwrite with overrun pulse, clear on accept.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.rx_data     <= '0;
         bus.rx_valid    <= 1'b0;
         bus.frame_err   <= 1'b0;
         bus.overrun_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
         bus.parity_err  <= 1'b0;
`endif
      end else begin
         bus.overrun_err <= 1'b0;
         if (done_p1) begin
            bus.rx_data     <= shreg;
            bus.frame_err   <= ferr_acc;
            bus.rx_valid    <= 1'b1;
            bus.overrun_err <= bus.rx_valid && !bus.rx_ready;
`ifdef UART_RX_PARITY_EN
            bus.parity_err  <= perr_acc;
`endif
         end else if (bus.rx_valid && bus.rx_ready) begin
            bus.rx_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param: OVS=16, DATA_W=8, tick every 4 clk (64 clk per bit).
module tb_uart_rx_param;

   localparam int BIT_CLK = 64;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       tick = 1'b0;
   logic       rx_en = 1'b1;
   logic       rx = 1'b1;
   logic [3:0] n_bits = 4'd8;
   logic       stop_bits = 1'b0;
   logic       busy;
   logic [1:0] tdiv = 2'd0;
`ifdef UART_RX_PARITY_EN
   logic [1:0] parity_mode = 2'b00;
`endif

   uart_rx_param_if #(.DATA_W(8)) bus ();

   uart_rx_param #(.DATA_W(8), .OVS(16), .SYNC_STAGES(2)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .tick        (tick),
      .rx_en       (rx_en),
      .rx          (rx),
      .n_bits      (n_bits),
      .stop_bits   (stop_bits),
`ifdef UART_RX_PARITY_EN
      .parity_mode (parity_mode),
`endif
      .busy        (busy),
      .bus         (bus)
   );

   always #5 clk = ~clk;

   // Baud-generator stand-in: one-clk tick every fourth clk.
   always @(posedge clk) begin
      tdiv <= tdiv + 2'd1;
      tick <= (tdiv == 2'd3);
   end

   int         checks = 0;
   int         failures = 0;
   int         vld_cnt = 0;
   int         acc_cnt = 0;
   int         ovr_cnt = 0;
   int         busy_cnt = 0;
   logic [7:0] cap_data = 8'h00;
   logic       cap_ferr = 1'b0;

   // Monitor on the falling edge, away from the active edge.
   always @(negedge clk) begin
      if (bus.rx_valid) begin
         vld_cnt  = vld_cnt + 1;
         cap_data = bus.rx_data;
         cap_ferr = bus.frame_err;
      end
      if (bus.rx_valid && bus.rx_ready) acc_cnt = acc_cnt + 1;
      if (bus.overrun_err) ovr_cnt = ovr_cnt + 1;
      if (busy) busy_cnt = busy_cnt + 1;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks = checks + 1;
      if (act !== exp) begin
         failures = failures + 1;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic drive_bit(input logic v, input int n);
      rx = v;
      repeat (n) @(negedge clk);
   endtask

   task automatic stop_bit(input logic low);
      if (low) begin
         drive_bit(1'b0, 44);
         drive_bit(1'b1, BIT_CLK - 44);
      end else begin
         drive_bit(1'b1, BIT_CLK);
      end
   endtask

   task automatic send_frame(input logic [7:0] d, input int nb_in, input int nb_eff,
                             input logic sb, input logic s0low, input logic s1low,
                             input logic par_en, input logic par_bit);
      n_bits    = nb_in[3:0];
      stop_bits = sb;
      drive_bit(1'b0, BIT_CLK);
      for (int i = 0; i < nb_eff; i++) drive_bit(d[i], BIT_CLK);
      if (par_en) drive_bit(par_bit, BIT_CLK);
      stop_bit(s0low);
      if (sb) stop_bit(s1low);
      drive_bit(1'b1, 96);
   endtask

   typedef struct {
      logic [7:0] data;
      int         nb_in;
      int         nb_eff;
      logic       sb;
      logic       s0low;
      logic       s1low;
      logic [7:0] exp_data;
      logic       exp_ferr;
   } vec_t;

   vec_t vecs[9];

   initial begin
      int v0, a0, o0, b0;

      vecs[0] = '{8'hA5, 8, 8, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b0};
      vecs[1] = '{8'h15, 5, 5, 1'b1, 1'b0, 1'b0, 8'h15, 1'b0};
      vecs[2] = '{8'h15, 5, 5, 1'b1, 1'b0, 1'b1, 8'h15, 1'b1};
      vecs[3] = '{8'h3C, 8, 8, 1'b0, 1'b1, 1'b0, 8'h3C, 1'b1};
      vecs[4] = '{8'h0A, 3, 5, 1'b0, 1'b0, 1'b0, 8'h0A, 1'b0};
      vecs[5] = '{8'hFF, 15, 8, 1'b0, 1'b0, 1'b0, 8'hFF, 1'b0};
      vecs[6] = '{8'h00, 8, 8, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0};
      vecs[7] = '{8'hD5, 7, 7, 1'b1, 1'b1, 1'b0, 8'h55, 1'b1};
      vecs[8] = '{8'hEB, 6, 6, 1'b0, 1'b0, 1'b0, 8'h2B, 1'b0};

      bus.rx_ready = 1'b1;
      repeat (5) @(negedge clk);
      check("reset_valid", bus.rx_valid, 0);
      check("reset_data", bus.rx_data, 0);
      check("reset_ferr", bus.frame_err, 0);
      check("reset_ovr", bus.overrun_err, 0);
      check("reset_busy", busy, 0);
      rst_n = 1'b1;
      repeat (20) @(negedge clk);

      // Table-driven frames with the consumer always ready.
      for (int k = 0; k < 9; k++) begin
         v0 = vld_cnt; o0 = ovr_cnt;
         send_frame(vecs[k].data, vecs[k].nb_in, vecs[k].nb_eff, vecs[k].sb,
                    vecs[k].s0low, vecs[k].s1low, 1'b0, 1'b0);
         check($sformatf("v%0d_valid_cycles", k), vld_cnt - v0, 1);
         check($sformatf("v%0d_data", k), cap_data, vecs[k].exp_data);
         check($sformatf("v%0d_ferr", k), cap_ferr, vecs[k].exp_ferr);
         check($sformatf("v%0d_no_ovr", k), ovr_cnt - o0, 0);
         check($sformatf("v%0d_busy_end", k), busy, 0);
      end

      // False start: line low for 4 ticks only.
      v0 = vld_cnt; o0 = ovr_cnt; b0 = busy_cnt;
      drive_bit(1'b0, 16);
      drive_bit(1'b1, 100);
      check("false_start_no_valid", vld_cnt - v0, 0);
      check("false_start_went_busy", (busy_cnt - b0) > 0, 1);
      check("false_start_busy_end", busy, 0);
      check("false_start_no_ovr", ovr_cnt - o0, 0);

      // Overrun: two frames without accepting.
      bus.rx_ready = 1'b0;
      o0 = ovr_cnt; a0 = acc_cnt;
      send_frame(8'h11, 8, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      check("ovr_first_valid", bus.rx_valid, 1);
      check("ovr_first_data", bus.rx_data, 8'h11);
      check("ovr_first_no_pulse", ovr_cnt - o0, 0);
      send_frame(8'h22, 8, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      check("ovr_pulse_once", ovr_cnt - o0, 1);
      check("ovr_second_valid", bus.rx_valid, 1);
      check("ovr_second_data", bus.rx_data, 8'h22);
      check("ovr_second_ferr", bus.frame_err, 0);
      bus.rx_ready = 1'b1;
      repeat (2) @(negedge clk);
      check("ovr_accept_once", acc_cnt - a0, 1);
      check("ovr_valid_cleared", bus.rx_valid, 0);

      // Reset in the middle of the data bits.
      n_bits = 4'd8; stop_bits = 1'b0;
      drive_bit(1'b0, BIT_CLK);
      drive_bit(1'b1, BIT_CLK);
      drive_bit(1'b0, BIT_CLK);
      drive_bit(1'b1, 20);
      check("mid_frame_busy", busy, 1);
      rst_n = 1'b0;
      rx = 1'b1;
      repeat (2) @(negedge clk);
      check("rst_valid", bus.rx_valid, 0);
      check("rst_data", bus.rx_data, 0);
      check("rst_busy", busy, 0);
      check("rst_ferr", bus.frame_err, 0);
      repeat (8) @(negedge clk);
      rst_n = 1'b1;
      drive_bit(1'b1, BIT_CLK);
      v0 = vld_cnt;
      send_frame(8'h5A, 8, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      check("post_rst_valid_cycles", vld_cnt - v0, 1);
      check("post_rst_data", cap_data, 8'h5A);
      check("post_rst_ferr", cap_ferr, 0);

`ifdef UART_RX_PARITY_EN
      // Even parity over 0x07 (three ones).
      parity_mode = 2'b01;
      bus.rx_ready = 1'b0;
      send_frame(8'h07, 8, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      check("par_bad_data", bus.rx_data, 8'h07);
      check("par_bad_err", bus.parity_err, 1);
      bus.rx_ready = 1'b1;
      repeat (2) @(negedge clk);
      bus.rx_ready = 1'b0;
      send_frame(8'h07, 8, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      check("par_good_data", bus.rx_data, 8'h07);
      check("par_good_err", bus.parity_err, 0);
      bus.rx_ready = 1'b1;
      parity_mode = 2'b00;
      repeat (2) @(negedge clk);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
